// File: rtl/usb_tx_encode.sv
// usb_tx_encode: full-speed USB transmit line encoder.
// Takes packet bytes over a valid/ready handshake and sends them LSB first.
// It prepends SYNC, inserts stuff bits, applies NRZI coding and closes each
// packet with an EOP (two bit periods of SE0, then one bit period of J).
// The line registers change only on bit boundaries.
module usb_tx_encode #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LEN + 1);

    localparam logic [TW-1:0] TIMER_MAX   = TW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] STUFF_LIMIT = OW'(STUFF_LEN);
    localparam logic [7:0]    SYNC_BYTE   = 8'h80;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_EOP  = 2'd3;

    // Registered state
    logic [1:0]    state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;   // index of the data bit currently on the line
    logic [7:0]    shift_q;     // bit_idx_q-th bit of the byte sits in shift_q[0]
    logic          last_q;      // latched tx_last for the byte being sent
    logic [OW-1:0] ones_q;      // consecutive 1s sent, stuff bits included
    logic [1:0]    eop_cnt_q;   // bit periods of EOP already completed

    // Next-state values
    logic [1:0]    state_d;
    logic [TW-1:0] timer_d;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift_d;
    logic          last_d;
    logic [OW-1:0] ones_d;
    logic [1:0]    eop_cnt_d;
    logic          d_plus_d;
    logic          d_minus_d;
    logic          tx_ready_d;
    logic          tx_busy_d;
    logic          tx_done_d;
    logic          tx_error_d;

    // Bit-level helpers
    logic bit_end;       // last clock of the current bit period
    logic stuff_pending; // the next bit period must carry a stuff 0
    logic emit;          // a new bit goes on the line at this edge
    logic emit_bit;      // value of that bit before NRZI coding
    logic go_eop;        // start SE0 at this edge

    assign bit_end       = (state_q != ST_IDLE) && (timer_q == TIMER_MAX);
    assign stuff_pending = (ones_q == STUFF_LIMIT);

    // Next-state logic: sequencing, byte handshake, bit stuffing and NRZI coding.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct in
    // combinational code because later lines read the values set above them.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        last_d     = last_q;
        ones_d     = ones_q;
        eop_cnt_d  = eop_cnt_q;
        d_plus_d   = d_plus;
        d_minus_d  = d_minus;
        tx_ready_d = 1'b0;
        tx_busy_d  = tx_busy;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        emit       = 1'b0;
        emit_bit   = 1'b0;
        go_eop     = 1'b0;

        if (state_q != ST_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                ones_d = '0;
                // The first byte is not taken here; it is held until SYNC ends.
                if (tx_valid) begin
                    state_d   = ST_SYNC;
                    tx_busy_d = 1'b1;
                    shift_d   = SYNC_BYTE;
                    bit_idx_d = 3'd0;
                    emit      = 1'b1;
                    emit_bit  = SYNC_BYTE[0];
                end
            end

            // SYNC is shifted out exactly like a data byte; only the
            // end-of-byte decision differs.
            ST_SYNC, ST_DATA: begin
                if (bit_end) begin
                    if (stuff_pending) begin
                        // Stuff 0: shift register frozen, bit index unchanged.
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        emit      = 1'b1;
                        emit_bit  = shift_q[1];
                    end else if ((state_q == ST_DATA) && last_q) begin
                        go_eop = 1'b1;
                    end else if (tx_valid) begin
                        state_d    = ST_DATA;
                        tx_ready_d = 1'b1;
                        shift_d    = tx_data;
                        last_d     = tx_last;
                        bit_idx_d  = 3'd0;
                        emit       = 1'b1;
                        emit_bit   = tx_data[0];
                    end else begin
                        // Underrun: abandon the packet with an EOP.
                        tx_error_d = 1'b1;
                        go_eop     = 1'b1;
                    end
                end
            end

            ST_EOP: begin
                if (bit_end) begin
                    if (eop_cnt_q == 2'd2) begin
                        state_d   = ST_IDLE;
                        eop_cnt_d = 2'd0;
                        tx_busy_d = 1'b0;
                        tx_done_d = 1'b1;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                        if (eop_cnt_q == 2'd1) begin
                            d_plus_d  = 1'b1;
                            d_minus_d = 1'b0;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (go_eop) begin
            state_d   = ST_EOP;
            eop_cnt_d = 2'd0;
            ones_d    = '0;
            d_plus_d  = 1'b0;
            d_minus_d = 1'b0;
        end

        // NRZI: a 0 toggles J<->K and a 1 holds the line.
        if (emit) begin
            d_plus_d  = emit_bit ? d_plus  : ~d_plus;
            d_minus_d = emit_bit ? d_minus : ~d_minus;
            ones_d    = emit_bit ? ones_q + OW'(1) : '0;
        end
    end

    // State and output registers; reset parks the line at idle J.
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            last_q    <= 1'b0;
            ones_q    <= '0;
            eop_cnt_q <= 2'd0;
            d_plus    <= 1'b1;
            d_minus   <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_error  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            ones_q    <= ones_d;
            eop_cnt_q <= eop_cnt_d;
            d_plus    <= d_plus_d;
            d_minus   <= d_minus_d;
            tx_ready  <= tx_ready_d;
            tx_busy   <= tx_busy_d;
            tx_done   <= tx_done_d;
            tx_error  <= tx_error_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_encode.sv
// tb_usb_tx_encode: directed bench for usb_tx_encode. A reference model turns
// each packet into the expected line symbols per bit period, plus the cycles
// where tx_ready and tx_error should pulse. A per-clock monitor loop then
// compares these against the DUT.
module tb_usb_tx_encode;

    localparam int CPB   = 8;
    localparam int STUFF = 6;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    usb_tx_encode #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LEN   (STUFF)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .d_plus  (d_plus),
        .d_minus (d_minus),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: one {d_plus,d_minus} symbol per bit period, plus ready cycles.
    logic [1:0] exp_sym_q[$];
    int         exp_ready_q[$];
    int         exp_err_cyc;
    int         exp_total;
    int         done_cyc;

    // Packet description
    logic [7:0] pkt[4];
    int         pkt_len;
    bit         underrun;

    // Reference model state
    logic       m_level;
    int         m_ones;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one bit through NRZI and stuffing, then queue the resulting symbols.
    task automatic m_emit(input bit b);
        if (!b) m_level = ~m_level;
        m_ones = b ? m_ones + 1 : 0;
        exp_sym_q.push_back({m_level, ~m_level});
        if (m_ones == STUFF) begin
            m_level = ~m_level;
            m_ones  = 0;
            exp_sym_q.push_back({m_level, ~m_level});
        end
    endtask

    task automatic build_model();
        exp_sym_q.delete();
        exp_ready_q.delete();
        m_level = 1'b1;
        m_ones  = 0;
        for (int i = 0; i < 8; i++) m_emit(i == 7);
        exp_ready_q.push_back(exp_sym_q.size() * CPB);
        for (int b = 0; b < pkt_len; b++) begin
            for (int i = 0; i < 8; i++) m_emit(pkt[b][i]);
            if (b < pkt_len - 1) exp_ready_q.push_back(exp_sym_q.size() * CPB);
        end
        exp_err_cyc = underrun ? exp_sym_q.size() * CPB : -1;
        exp_sym_q.push_back(2'b00);
        exp_sym_q.push_back(2'b00);
        exp_sym_q.push_back(2'b10);
        exp_total = exp_sym_q.size() * CPB;
    endtask

    // Drive one packet and watch it clock by clock until the expected tx_done.
    // glitch: drop tx_valid briefly in the middle of every bit period.
    // hold_valid: keep tx_valid high after the last byte has been accepted.
    task automatic run_packet(input bit glitch, input bit hold_valid);
        logic [1:0] cur;
        int         accepted;
        int         exp_r;
        bit         want_valid;
        build_model();
        accepted   = 0;
        done_cyc   = -1;
        cur        = 2'b10;
        want_valid = 1'b1;
        tx_data    = pkt[0];
        tx_last    = (pkt_len == 1) && !underrun;
        tx_valid   = 1'b1;
        tick();
        for (int c = 0; c <= exp_total; c++) begin
            if ((c % CPB == 0) && (c < exp_total)) cur = exp_sym_q.pop_front();
            check("line", int'({d_plus, d_minus}), int'(cur));
            check("busy", int'(tx_busy), int'(c < exp_total));
            check("done", int'(tx_done), int'(c == exp_total));
            check("error", int'(tx_error), int'(c == exp_err_cyc));
            if (tx_done) done_cyc = c;
            if (tx_ready) begin
                exp_r = (exp_ready_q.size() != 0) ? exp_ready_q.pop_front() : -1;
                check("ready_cycle", c, exp_r);
                accepted++;
                if (accepted < pkt_len) begin
                    tx_data = pkt[accepted];
                    tx_last = (accepted == pkt_len - 1) && !underrun;
                end else begin
                    want_valid = hold_valid;
                end
            end
            if (c == exp_total) break;
            tx_valid = (glitch && (c % CPB == 3)) ? 1'b0 : want_valid;
            tick();
        end
        check("ready_missing", exp_ready_q.size(), 0);
        check("done_cycle", done_cyc, exp_total);
        if (!hold_valid) tx_valid = 1'b0;
    endtask

    int done_seen;

    initial begin
        n_rst    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        underrun = 1'b0;
        #12;
        check("rst_d_plus", int'(d_plus), 1);
        check("rst_d_minus", int'(d_minus), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_ready", int'(tx_ready), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_error", int'(tx_error), 0);
        n_rst = 1'b1;
        tick();
        tick();

        // Single zero byte: all toggles, 152 clocks from start to tx_done.
        pkt[0] = 8'h00; pkt_len = 1; underrun = 1'b0;
        run_packet(1'b0, 1'b0);
        check("total_00", done_cyc, 152);
        tick();

        // All ones: stuff toggle after the sixth 1 (SYNC's final 1 counts).
        pkt[0] = 8'hFF; pkt_len = 1; underrun = 1'b0;
        run_packet(1'b0, 1'b0);
        tick();

        // Two bytes, with tx_valid glitching mid-bit; ready pulses at 64 and 128.
        pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt_len = 2; underrun = 1'b0;
        run_packet(1'b1, 1'b0);
        tick();

        // Underrun after a non-final byte: tx_error, then EOP, then tx_done.
        pkt[0] = 8'h5A; pkt_len = 1; underrun = 1'b1;
        run_packet(1'b0, 1'b0);
        tick();

        // Stuff bit after the final data bit, before SE0; tx_valid held through
        // EOP must not produce tx_ready and starts a new packet one cycle after tx_done.
        pkt[0] = 8'hFC; pkt_len = 1; underrun = 1'b0;
        run_packet(1'b0, 1'b1);
        tick();
        check("restart_busy", int'(tx_busy), 1);
        check("restart_line", int'({d_plus, d_minus}), 1);
        n_rst    = 1'b0;
        tx_valid = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();

        // Asynchronous reset in the middle of DATA: idle J at once, no tx_done.
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        tick();
        for (int c = 0; c < 100; c++) begin
            if (c == 80) tx_valid = 1'b0;
            tick();
        end
        n_rst = 1'b0;
        #1;
        check("midrst_d_plus", int'(d_plus), 1);
        check("midrst_d_minus", int'(d_minus), 0);
        check("midrst_busy", int'(tx_busy), 0);
        check("midrst_done", int'(tx_done), 0);
        tick();
        tick();
        n_rst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (tx_done || tx_busy || !d_plus || d_minus) done_seen++;
        end
        check("post_rst_quiet", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_encode.md
Name: usb_tx_encode

Overview:
- Full-speed USB transmit-side line encoder. It is the counterpart of the receive-path NRZI decode block.
- Accepts packet bytes over a valid/ready handshake and serializes them LSB first.
- Prepends SYNC, applies bit stuffing and NRZI encoding, and terminates the packet with EOP on d_plus/d_minus.
- Sits between the TX packet controller and the USB pad drivers.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit period (96 MHz clk for 12 Mbps); minimum 2
STUFF_LEN, 6, consecutive 1s that trigger insertion of a stuff 0

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tx_data  input  8  packet byte, sent LSB first
tx_valid  input  1  tx_data/tx_last are valid
tx_last  input  1  accompanies final byte of packet
tx_ready  output  1  one-cycle pulse: byte accepted into shift register
d_plus  output  1  D+ line drive
d_minus  output  1  D- line drive
tx_busy  output  1  high from SYNC start until EOP idle-J period completes
tx_done  output  1  one-cycle pulse at end of EOP
tx_error  output  1  one-cycle pulse on underrun

Behaviour:
- Reset (async, any state): d_plus=1, d_minus=0 (idle J). tx_ready=0, tx_busy=0, tx_done=0, tx_error=0. Ones counter=0, bit timer=0, state IDLE. All outputs are registered.
- Bit timer: counts 0..CLKS_PER_BIT-1 while not IDLE. Line value changes only on the clock edge where the timer wraps to 0 (bit boundary).
- States:
  - IDLE: line J. On clk edge with tx_valid=1: go to SYNC, drive first SYNC bit immediately (line registers update on that same edge), tx_busy=1. tx_ready is not asserted; the first byte is held by the source.
  - SYNC: sends 8'h80 LSB first (0000_0001), 8 bit periods. On the last clock of the last SYNC bit period: if tx_valid=1, pulse tx_ready, latch tx_data/tx_last, go to DATA; else go to EOP and pulse tx_error.
  - DATA: shifts 8 bits per byte, plus any stuff bits. On the last clock of the final bit period of the byte (including a pending stuff bit):
    - if the latched tx_last=1: go to EOP;
    - else if tx_valid=1: pulse tx_ready, latch, stay in DATA;
    - else (underrun): pulse tx_error, go to EOP.
  - EOP: 2 bit periods SE0 (d_plus=0, d_minus=0), then 1 bit period J. On the last clock of the J period: pulse tx_done, deassert tx_busy, return to IDLE. A tx_valid seen in that same cycle is ignored; it is accepted next cycle.
- NRZI: data bit 0 toggles the line state (J<->K); bit 1 holds it. Outside SE0, d_minus = ~d_plus.
- Bit stuffing:
  - The ones counter increments on each transmitted 1 and clears on each transmitted 0, including stuff bits.
  - The counter spans SYNC and DATA (the SYNC final 1 counts), and is cleared on entering EOP and in IDLE.
  - When the counter reaches STUFF_LEN, the next bit period carries a stuff 0 (toggle) before the next data bit. The shift register is frozen during the stuff bit.
  - A stuff bit required after the final data bit is sent before EOP.
- Simultaneous events: tx_ready never pulses in IDLE or EOP. tx_valid deassertion mid-byte has no effect; only byte-boundary sampling matters.
- Reset mid-packet returns the line to J with no EOP and no tx_done.

Test Plan:
- Reset: assert n_rst=0 mid-DATA -> d_plus=1, d_minus=0, tx_busy=0 within the same cycle; no tx_done pulse.
- Single byte 8'h00, tx_last=1:
  - SYNC d_plus per bit: 0,1,0,1,0,1,0,0.
  - Data: 8 toggles 1,0,1,0,1,0,1,0.
  - Then SE0 for 16 clks, J for 8 clks, tx_done pulse; total 8*(8+8+3)=152 clks from start to tx_done.
- Byte 8'hFF, tx_last=1: after SYNC, the line holds at 0 for 5 bit periods. The ones count hits 6 and a stuff toggle goes to d_plus=1, then 3 more holds. That is 9 bit periods in DATA, then EOP.
- Two bytes 8'hA5 then 8'h3C: exactly two tx_ready pulses, 64 clks apart, each on the last clock of the preceding byte/SYNC. Decoded line bits: A5 LSB first 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Underrun: first byte tx_last=0, tx_valid=0 at its end -> tx_error pulse, SE0 starts at the next bit boundary, tx_done follows EOP.
- Stuff at packet end: byte 8'hFC (bits 0,0,1,1,1,1,1,1), tx_last=1 -> six 1s reached on the final bit; one stuff toggle precedes SE0.
